instr_exec_unit: RTL and testbench
==================================

INSTR_EXEC_UNIT -- requirements
Module: instr_exec_unit

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning register/memory word width in bits.
REQ-002 The block SHALL have parameter NREG, default 4, a power of two ≥2, meaning register count; RW = log2(NREG).
REQ-003 The block SHALL have parameter MEM_DEPTH, default 8, a power of two ≥2, meaning memory word count; AW = log2(MEM_DEPTH).
REQ-004 The block SHALL have derived width IW = 3+2*RW+DW, meaning the instruction width.
REQ-005 The block SHALL have port clk  input  1  system clock, rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port instruction  input  IW  = {op[2:0], rd[RW-1:0], rs[RW-1:0], imm[DW-1:0]}.
REQ-008 The block SHALL have port instr_valid  input  1  instruction offered.
REQ-009 The block SHALL have port instr_ready  output  1  block can accept.
REQ-010 The block SHALL have port done  output  1  one-cycle retire pulse.
REQ-011 The block SHALL have port err  output  1  one-cycle pulse, out-of-range address on the retiring instruction.
REQ-012 The block SHALL have port regs  output  NREG*DW  flat register file, r0 in bits [DW-1:0].
REQ-013 The block SHALL have port memory  output  MEM_DEPTH*DW  flat memory, word 0 in bits [DW-1:0].
REQ-014 The block SHALL have port zero, carry  output  1 each  status flags.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and WB; instr_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE with instr_valid=1, the instruction SHALL be latched and the state SHALL go to EXEC; instr_valid in EXEC/WB SHALL be ignored.
REQ-017 The opcodes SHALL be:
- 000 LOADI: rd=imm
- 001 LOAD: rd=mem[imm]
- 010 STORE: mem[imm]=rd
- 011 ADD: rd=rd+rs
- 100 SUB: rd=rd-rs
- 101 AND: rd=rd&rs
- 110 XOR: rd=rd^rs
- 111 SHL: rd=rd<<imm[2:0], zero-filled.
REQ-018 LOADI, STORE and ALU ops SHALL write at the edge ending EXEC and then go to IDLE; LOAD SHALL read in EXEC, write rd at the edge ending WB, and then go to IDLE.
REQ-019 done SHALL be registered and high for exactly the cycle after the write edge; back-to-back accept SHALL be possible in that same cycle.
REQ-020 Latency SHALL be: the result is visible on regs/memory 2 clocks after the accept edge (3 for LOAD).
REQ-021 Arithmetic SHALL be modulo 2^DW; carry SHALL equal the ADD carry-out, or SUB borrow (rd<rs unsigned), or the last bit shifted out for SHL; carry SHALL be 0 for AND/XOR/LOADI/LOAD.
REQ-022 zero SHALL be 1 iff the written rd value is 0, updated by every op except STORE; STORE SHALL leave both flags unchanged.
REQ-023 When rd==rs, ALU ops SHALL use the pre-write value for both operands.
REQ-024 Address range: if imm ≥ MEM_DEPTH, LOAD SHALL write 0 to rd, STORE SHALL not modify memory, and err SHALL pulse together with done.
REQ-025 An asynchronous reset asserted mid-operation SHALL abort the instruction with no partial write, and no done SHALL follow.

Reset
REQ-026 While rst=1, the block SHALL hold:
- state IDLE
- all registers and all memory words 0
- zero=0, carry=0, done=0, err=0
- instr_ready=1 after release.
REQ-027 The first accept SHALL be possible on the first rising edge with rst=0.

Verification (DW=8, NREG=4, MEM_DEPTH=8)
REQ-028 LOADI r1,0x3C then LOADI r2,0x4F then ADD r1,r2 -> regs r1=0x8B, carry=0, zero=0, done pulses 3 times, each 2 clocks after its accept.
REQ-029 STORE r1 to addr 5 then LOAD r3 from addr 5 -> memory word5=0x8B; r3=0x8B 3 clocks after LOAD accept; instr_ready low for 2 cycles.
REQ-030 LOADI r0,0x10; SUB r0,r0 -> r0=0x00, zero=1, carry=0; LOADI r1,0x01; SUB r1,r2(0x4F) -> r1=0xB2, carry=1.
REQ-031 STORE to addr 9 and LOAD r2 from addr 12 -> memory unchanged, r2=0x00, err and done pulse together for each.
REQ-032 SHL r2(0x81) by 1 -> r2=0x02, carry=1; XOR r2,r2 -> r2=0x00, zero=1, carry=0.
REQ-033 Assert rst during the EXEC of ADD, and during the WB of LOAD -> no register/memory change, no done, everything 0, instr_ready=1 after release.

Source files
------------

// File: rtl/instr_exec_unit.sv
// Multi-cycle instruction execution unit: small register file, flat memory,
// IDLE/EXEC/WB sequencing with a one-cycle retire pulse and range-error flag.
module instr_exec_unit #(
  parameter int unsigned DW        = 8,
  parameter int unsigned NREG      = 4,
  parameter int unsigned MEM_DEPTH = 8,
  localparam int unsigned RW = $clog2(NREG),
  localparam int unsigned AW = $clog2(MEM_DEPTH),
  localparam int unsigned IW = 3 + 2 * RW + DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IW-1:0]           instruction,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  output logic                    done,
  output logic                    err,
  output logic [NREG*DW-1:0]      regs,
  output logic [MEM_DEPTH*DW-1:0] memory,
  output logic                    zero,
  output logic                    carry
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [2:0] OP_LOADI = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_SHL   = 3'b111;

  logic [1:0]    state, state_nx;
  logic [IW-1:0] ir;
  logic [DW-1:0] reg_q [NREG];
  logic [DW-1:0] mem_q [MEM_DEPTH];
  logic [DW-1:0] load_q;

  logic [2:0]    op;
  logic [RW-1:0] rd_i, rs_i;
  logic [DW-1:0] imm;
  logic [AW-1:0] addr;
  logic          in_range;

  assign op       = ir[IW-1 -: 3];
  assign rd_i     = ir[DW+RW +: RW];
  assign rs_i     = ir[DW +: RW];
  assign imm      = ir[DW-1:0];
  assign addr     = imm[AW-1:0];
  assign in_range = 32'(imm) < MEM_DEPTH;

  // ALU: both operands read before any write, so rd==rs sees the old value
  logic [DW-1:0] a, b, alu_res;
  logic [DW:0]   wide;
  logic          alu_c;

  always_comb begin
    a       = reg_q[rd_i];
    b       = reg_q[rs_i];
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_LOADI: alu_res = imm;
      OP_ADD: begin
        wide    = {1'b0, a} + {1'b0, b};
        alu_res = wide[DW-1:0];
        alu_c   = wide[DW];
      end
      OP_SUB: begin
        alu_res = a - b;
        alu_c   = a < b;
      end
      OP_AND: alu_res = a & b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        wide    = {1'b0, a} << imm[2:0];
        alu_res = wide[DW-1:0];
        alu_c   = wide[DW];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (instr_valid) state_nx = S_EXEC;
      S_EXEC:  state_nx = (op == OP_LOAD) ? S_WB : S_IDLE;
      S_WB:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: LOAD samples memory in EXEC and retires from WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir          <= '0;
      load_q      <= '0;
      zero        <= 1'b0;
      carry       <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      instr_ready <= 1'b1;
      for (int i = 0; i < int'(NREG); i++)      reg_q[i] <= '0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      done        <= 1'b0;
      err         <= 1'b0;
      instr_ready <= (state_nx == S_IDLE);
      case (state)
        S_IDLE: if (instr_valid) ir <= instruction;
        S_EXEC: begin
          if (op == OP_LOAD) begin
            load_q <= in_range ? mem_q[addr] : '0;
          end else if (op == OP_STORE) begin
            if (in_range) mem_q[addr] <= a;
            done <= 1'b1;
            err  <= !in_range;
          end else begin
            reg_q[rd_i] <= alu_res;
            zero        <= (alu_res == '0);
            carry       <= alu_c;
            done        <= 1'b1;
          end
        end
        S_WB: begin
          reg_q[rd_i] <= load_q;
          zero        <= (load_q == '0);
          carry       <= 1'b0;
          done        <= 1'b1;
          err         <= !in_range;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    regs   = '0;
    memory = '0;
    for (int i = 0; i < int'(NREG); i++)      regs[i*DW +: DW]   = reg_q[i];
    for (int i = 0; i < int'(MEM_DEPTH); i++) memory[i*DW +: DW] = mem_q[i];
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a latency-counting ISA model.
module tb_instr_exec_unit;

  localparam int DW = 8;
  localparam int NREG = 4;
  localparam int MEM_DEPTH = 8;
  localparam int IW = 15;

  localparam logic [2:0] LOADI = 3'b000, LOAD = 3'b001, STORE = 3'b010, ADD = 3'b011;
  localparam logic [2:0] SUB = 3'b100, AND_ = 3'b101, XOR_ = 3'b110, SHL = 3'b111;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [IW-1:0]           instruction;
  logic                    instr_valid;
  logic                    instr_ready, done, err, zero, carry;
  logic [NREG*DW-1:0]      regs;
  logic [MEM_DEPTH*DW-1:0] memory;

  instr_exec_unit #(.DW(DW), .NREG(NREG), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .done(done), .err(err), .regs(regs),
    .memory(memory), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [IW-1:0] enc(logic [2:0] op, int rd, int rs, int imm);
    return {op, 2'(rd), 2'(rs), 8'(imm)};
  endfunction

  // ISA-level model: architectural state plus cycles left until retirement
  int m_regs [NREG];
  int m_mem  [MEM_DEPTH];
  int m_zero, m_carry, m_done, m_err, m_busy;
  logic [IW-1:0] m_ir;
  logic p_rst = 1'b1, p_valid = 1'b0;
  logic [IW-1:0] p_instr = '0;

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 0;
    foreach (m_mem[i])  m_mem[i] = 0;
    m_zero = 0; m_carry = 0; m_done = 0; m_err = 0; m_busy = 0;
  endtask

  task automatic model_retire(logic [IW-1:0] ins);
    int op, rd, rs, imm, a, b, r, sh;
    op = int'(ins[14:12]); rd = int'(ins[11:10]); rs = int'(ins[9:8]); imm = int'(ins[7:0]);
    a = m_regs[rd]; b = m_regs[rs];
    m_done = 1;
    r = 0;
    if (op == 2) begin
      if (imm < MEM_DEPTH) m_mem[imm] = a;
      else m_err = 1;
      return;
    end
    m_carry = 0;
    case (op)
      0: r = imm;
      1: if (imm < MEM_DEPTH) r = m_mem[imm]; else begin r = 0; m_err = 1; end
      3: begin r = (a + b) % 256; m_carry = (a + b > 255) ? 1 : 0; end
      4: begin r = (a - b + 256) % 256; m_carry = (a < b) ? 1 : 0; end
      5: r = a & b;
      6: r = a ^ b;
      default: begin
        sh = imm % 8;
        r = (a * (1 << sh)) % 256;
        m_carry = (sh == 0) ? 0 : ((a >> (8 - sh)) & 1);
      end
    endcase
    m_regs[rd] = r;
    m_zero = (r == 0) ? 1 : 0;
  endtask

  task automatic model_step(logic v, logic [IW-1:0] ins);
    m_done = 0; m_err = 0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) model_retire(m_ir);
    end else if (v) begin
      m_ir = ins;
      m_busy = (ins[14:12] == LOAD) ? 2 : 1;
    end
  endtask

  // Advance the model by the edge just past, then compare mid-cycle
  always @(negedge clk) begin
    logic [NREG*DW-1:0] er;
    logic [MEM_DEPTH*DW-1:0] em;
    if (rst || p_rst) model_reset();
    else model_step(p_valid, p_instr);
    for (int i = 0; i < NREG; i++)      er[i*DW +: DW] = 8'(m_regs[i]);
    for (int i = 0; i < MEM_DEPTH; i++) em[i*DW +: DW] = 8'(m_mem[i]);
    check("regs", 128'(regs), 128'(er));
    check("memory", 128'(memory), 128'(em));
    check("zero", 128'(zero), 128'(m_zero));
    check("carry", 128'(carry), 128'(m_carry));
    check("done", 128'(done), 128'(m_done));
    check("err", 128'(err), 128'(m_err));
    check("instr_ready", 128'(instr_ready), 128'(m_busy == 0));
    p_rst = rst; p_valid = instr_valid; p_instr = instruction;
  end

  function automatic logic [7:0] r_of(int i);
    logic [NREG*DW-1:0] v;
    v = regs;
    return v[i*DW +: DW];
  endfunction

  task automatic issue(logic [2:0] op, int rd, int rs, int imm);
    int n = 0;
    while (!instr_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!instr_ready) check("accept_timeout", 128'(instr_ready), 128'(1));
    instruction = enc(op, rd, rs, imm);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  // Issue and stop in the cycle where done is expected
  task automatic run(logic [2:0] op, int rd, int rs, int imm);
    issue(op, rd, rs, imm);
    if (op == LOAD) @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1 check("rst_regs", 128'(regs), 128'(0));
    check("rst_memory", 128'(memory), 128'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_ready", 128'(instr_ready), 128'(1));
    check("rst_flags", 128'({zero, carry, done, err}), 128'(0));
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instruction = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_regs", 128'(regs), 128'(0));
    check("reset_ready", 128'(instr_ready), 128'(1));
    rst = 1'b0;

    run(LOADI, 1, 0, 8'h3C);
    check("loadi_r1", 128'(r_of(1)), 128'(8'h3C));
    check("loadi_done", 128'(done), 128'(1));
    run(LOADI, 2, 0, 8'h4F);
    run(ADD, 1, 2, 0);
    check("add_r1", 128'(r_of(1)), 128'(8'h8B));
    check("add_flags", 128'({done, zero, carry}), 128'(3'b100));

    run(STORE, 1, 0, 5);
    issue(LOAD, 3, 0, 5);
    check("load_busy0", 128'(instr_ready), 128'(0));
    @(posedge clk); #1;
    check("load_busy1", 128'(instr_ready), 128'(0));
    @(posedge clk); #1;
    check("load_r3", 128'({done, instr_ready, r_of(3)}), 128'({2'b11, 8'h8B}));
    check("store_mem5", 128'(memory), 128'(64'h0000_8B00_0000_0000));

    run(LOADI, 0, 0, 8'h10);
    run(SUB, 0, 0, 0);
    check("sub_self", 128'({r_of(0), zero, carry}), 128'({8'h00, 2'b10}));
    run(LOADI, 1, 0, 8'h01);
    run(SUB, 1, 2, 0);
    check("sub_borrow", 128'({r_of(1), carry}), 128'({8'hB2, 1'b1}));

    run(STORE, 1, 0, 9);
    check("store_oor", 128'({done, err, memory}), 128'({2'b11, 64'h0000_8B00_0000_0000}));
    run(LOAD, 2, 0, 12);
    check("load_oor", 128'({done, err, r_of(2)}), 128'({2'b11, 8'h00}));

    run(LOADI, 2, 0, 8'h81);
    run(SHL, 2, 0, 1);
    check("shl", 128'({r_of(2), carry}), 128'({8'h02, 1'b1}));
    run(XOR_, 2, 2, 0);
    check("xor_self", 128'({r_of(2), zero, carry}), 128'({8'h00, 2'b10}));

    issue(ADD, 1, 1, 0);
    pulse_rst();
    run(LOADI, 1, 0, 8'h55);
    run(STORE, 1, 0, 2);
    issue(LOAD, 3, 0, 2);
    @(posedge clk); #1;
    pulse_rst();

    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        instr_valid = ($urandom_range(0, 9) < 7);
        instruction = enc(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                      : int'($urandom_range(0, 11)));
        @(posedge clk); #1;
      end
    end
    instr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
